// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the memory stall controller: state encodings and
// the default load data width.
package mem_stall_ctrl_pkg;

    // Default width of the load data path.
    localparam int MSC_DWIDTH = 32;

    // Outstanding-request tracker states; WAIT_ID means both an instruction
    // fetch and a data access are in flight.
    typedef enum logic [1:0] {
        MSC_IDLE    = 2'd0,
        MSC_WAIT_I  = 2'd1,
        MSC_WAIT_D  = 2'd2,
        MSC_WAIT_ID = 2'd3
    } msc_state_e;

endpackage : mem_stall_ctrl_pkg

// File: rtl/mem_stall_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous active-low clear. Used to count
// stalled cycles; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: step when enabled and not yet saturated.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/mem_stall_ctrl.sv
// Memory stall controller. Tracks outstanding I-cache and D-cache requests,
// holds the pipeline stall line high until every outstanding response has
// returned, buffers the D-cache load word for the transfer register, and
// flags responses that arrive with no matching request outstanding.
// Optional build macro MEM_STALL_PERF_EN adds a saturating stall-cycle
// counter output (stall_cycles).
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int DWIDTH = MSC_DWIDTH
`ifdef MEM_STALL_PERF_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_re,
    input  logic              icache_resp_val,
    input  logic              dcache_re,
    input  logic [3:0]        dcache_we,
    input  logic              dcache_resp_val,
    input  logic [DWIDTH-1:0] dcache_dout,
    output logic              stall,
    output logic [DWIDTH-1:0] dout,
    output logic              err_spurious
`ifdef MEM_STALL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);

    msc_state_e        state_q;
    msc_state_e        state_d;
    logic              stall_q;
    logic              stall_d;
    logic              err_q;
    logic              err_d;
    logic [DWIDTH-1:0] hold_q;
    logic [DWIDTH-1:0] hold_d;

    // A store (any byte enabled) is a data request just like a load.
    logic d_req;
    assign d_req = dcache_re | (|dcache_we);

    // Next-state: requests are sampled only in IDLE; responses retire the
    // matching outstanding request. Spurious responses leave state alone.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        case (state_q)
            MSC_IDLE: begin
                if (icache_re && d_req) begin
                    state_d = MSC_WAIT_ID;
                end else if (icache_re) begin
                    state_d = MSC_WAIT_I;
                end else if (d_req) begin
                    state_d = MSC_WAIT_D;
                end
            end
            MSC_WAIT_I: begin
                if (icache_resp_val) begin
                    state_d = MSC_IDLE;
                end
            end
            MSC_WAIT_D: begin
                if (dcache_resp_val) begin
                    state_d = MSC_IDLE;
                end
            end
            MSC_WAIT_ID: begin
                if (icache_resp_val && dcache_resp_val) begin
                    state_d = MSC_IDLE;
                end else if (icache_resp_val) begin
                    state_d = MSC_WAIT_D;
                end else if (dcache_resp_val) begin
                    state_d = MSC_WAIT_I;
                end
            end
            default: state_d = MSC_IDLE;
        endcase
    end

    // Stall and spurious-response flags, registered so both change only on
    // posedge and are stable at the transfer registers' negedge.
    always_comb begin
        stall_d = (state_d != MSC_IDLE);
        err_d   = (icache_resp_val &&
                   ((state_q == MSC_IDLE) || (state_q == MSC_WAIT_D))) ||
                  (dcache_resp_val &&
                   ((state_q == MSC_IDLE) || (state_q == MSC_WAIT_I)));
    end

    // Load data hold: capture every D-cache response, spurious or not.
    always_comb begin
        hold_d = hold_q;
        if (dcache_resp_val) begin
            hold_d = dcache_dout;
        end
    end

    // State, flag and hold registers with synchronous active-low reset;
    // reset abandons anything in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q <= MSC_IDLE;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign stall        = stall_q;
    assign err_spurious = err_q;
    // Bypass the response word in the cycle it arrives, else present the hold.
    assign dout         = dcache_resp_val ? dcache_dout : hold_q;

`ifdef MEM_STALL_PERF_EN
    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .clr_n(reset),
        .en   (stall_q),
        .count(stall_cycles)
    );
`endif

endmodule : mem_stall_ctrl

// File: tb/tb_mem_stall_ctrl.sv
// Directed self-checking bench for mem_stall_ctrl. Inputs for a cycle are
// applied just after the posedge that starts it; registered outputs are
// sampled 1 time unit after each posedge. Define MEM_STALL_PERF_EN to also
// exercise the stall-cycle counter with a 4-bit width.
module tb_mem_stall_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          icache_re = 1'b0;
    logic          icache_resp_val = 1'b0;
    logic          dcache_re = 1'b0;
    logic [3:0]    dcache_we = 4'b0000;
    logic          dcache_resp_val = 1'b0;
    logic [DW-1:0] dcache_dout = '0;
    logic          stall;
    logic [DW-1:0] dout;
    logic          err_spurious;
`ifdef MEM_STALL_PERF_EN
    logic [3:0]    stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stall_ctrl #(
        .DWIDTH(DW)
`ifdef MEM_STALL_PERF_EN
        ,
        .CNT_WIDTH(4)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .icache_re      (icache_re),
        .icache_resp_val(icache_resp_val),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_resp_val(dcache_resp_val),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .dout           (dout),
        .err_spurious   (err_spurious)
`ifdef MEM_STALL_PERF_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    // Advance to just after the next posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        icache_re       = 1'b0;
        icache_resp_val = 1'b0;
        dcache_re       = 1'b0;
        dcache_we       = 4'b0000;
        dcache_resp_val = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        icache_re = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_stall cyc%0d: got %b want 0", c, stall);
            end
            checks++;
            if (err_spurious !== 1'b0) begin
                errors++;
                $display("FAIL reset_err cyc%0d: got %b want 0", c, err_spurious);
            end
            checks++;
            if (dout !== 32'h0) begin
                errors++;
                $display("FAIL reset_dout cyc%0d: got %h want 0", c, dout);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL release_stall: got %b want 1", stall);
        end
        icache_re       = 1'b0;
        icache_resp_val = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (stall !== 1'b0 || err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL release_retire: stall=%b err=%b want 0 0", stall, err_spurious);
        end
    endtask

    task automatic test_dual_issue();
        icache_re = 1'b1;
        dcache_re = 1'b1;
        tick();
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (stall !== (c <= 5)) begin
                errors++;
                $display("FAIL dual_stall cyc%0d: got %b want %b", c, stall, (c <= 5));
            end
            checks++;
            if (err_spurious !== 1'b0) begin
                errors++;
                $display("FAIL dual_err cyc%0d: got %b want 0", c, err_spurious);
            end
            icache_re       = 1'b0;
            dcache_re       = 1'b0;
            icache_resp_val = (c == 2);
            dcache_resp_val = (c == 5);
            dcache_dout     = (c == 5) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
            #1;
            if (c >= 5) begin
                checks++;
                if (dout !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL dual_dout cyc%0d: got %h want deadbeef", c, dout);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_store();
        dcache_we = 4'b0011;
        tick();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL store_stall_c1: got %b want 1", stall);
        end
        dcache_we       = 4'b0000;
        dcache_resp_val = 1'b1;
        dcache_dout     = 32'hA5A5_5A5A;
        icache_re       = 1'b1;
        tick();
        clear_inputs();
        dcache_dout = 32'hFFFF_FFFF;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL store_stall_c2: got %b want 0", stall);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL store_ignored_ireq: stall=%b err=%b want 0 0", stall, err_spurious);
        end
        checks++;
        if (dout !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL store_dout_hold: got %h want a5a55a5a", dout);
        end
    endtask

    task automatic test_spurious_d();
        dcache_resp_val = 1'b1;
        dcache_dout     = 32'h1234_5678;
        #1;
        checks++;
        if (dout !== 32'h1234_5678) begin
            errors++;
            $display("FAIL spur_d_bypass: got %h want 12345678", dout);
        end
        tick();
        clear_inputs();
        dcache_dout = 32'hCAFE_F00D;
        #1;
        checks++;
        if (err_spurious !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL spur_d_pulse: err=%b stall=%b want 1 0", err_spurious, stall);
        end
        checks++;
        if (dout !== 32'h1234_5678) begin
            errors++;
            $display("FAIL spur_d_hold: got %h want 12345678", dout);
        end
        tick();
        checks++;
        if (err_spurious !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL spur_d_end: err=%b stall=%b want 0 0", err_spurious, stall);
        end
    endtask

    task automatic test_spurious_i_in_wait_d();
        dcache_re = 1'b1;
        tick();
        dcache_re       = 1'b0;
        icache_resp_val = 1'b1;
        tick();
        icache_resp_val = 1'b0;
        checks++;
        if (err_spurious !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL spur_i_waitd: err=%b stall=%b want 1 1", err_spurious, stall);
        end
        dcache_resp_val = 1'b1;
        dcache_dout     = 32'h0000_00C3;
        tick();
        clear_inputs();
        checks++;
        if (err_spurious !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL spur_i_retire: err=%b stall=%b want 0 0", err_spurious, stall);
        end
    endtask

    task automatic test_reset_in_flight();
        icache_re = 1'b1;
        dcache_re = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rif_stall: got %b want 1", stall);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (stall !== 1'b0 || dout !== 32'h0) begin
            errors++;
            $display("FAIL rif_reset: stall=%b dout=%h want 0 0", stall, dout);
        end
        icache_resp_val = 1'b1;
        tick();
        icache_resp_val = 1'b0;
        checks++;
        if (err_spurious !== 1'b1 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rif_spur: err=%b stall=%b want 1 0", err_spurious, stall);
        end
        tick();
        checks++;
        if (err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL rif_pulse_len: got %b want 0", err_spurious);
        end
    endtask

    task automatic test_back_to_back();
        icache_re = 1'b1;
        dcache_re = 1'b1;
        tick();
        clear_inputs();
        icache_resp_val = 1'b1;
        dcache_resp_val = 1'b1;
        dcache_dout     = 32'h5555_AAAA;
        tick();
        clear_inputs();
        checks++;
        if (stall !== 1'b0 || err_spurious !== 1'b0) begin
            errors++;
            $display("FAIL b2b_both_resp: stall=%b err=%b want 0 0", stall, err_spurious);
        end
        icache_re = 1'b1;
        tick();
        icache_re = 1'b0;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reissue: got %b want 1", stall);
        end
        dcache_resp_val = 1'b1;
        dcache_dout     = 32'h7777_7777;
        tick();
        clear_inputs();
        checks++;
        if (err_spurious !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_spur_d_waiti: err=%b stall=%b want 1 1", err_spurious, stall);
        end
        icache_resp_val = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (stall !== 1'b0 || dout !== 32'h7777_7777) begin
            errors++;
            $display("FAIL b2b_end: stall=%b dout=%h want 0 77777777", stall, dout);
        end
    endtask

`ifdef MEM_STALL_PERF_EN
    task automatic test_perf_counter();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (stall_cycles !== 4'h0) begin
            errors++;
            $display("FAIL perf_clear: got %h want 0", stall_cycles);
        end
        dcache_re = 1'b1;
        tick();
        dcache_re = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (stall_cycles !== 4'h4) begin
            errors++;
            $display("FAIL perf_count4: got %h want 4", stall_cycles);
        end
        for (int c = 0; c < 16; c++) tick();
        checks++;
        if (stall_cycles !== 4'hF || stall !== 1'b1) begin
            errors++;
            $display("FAIL perf_saturate: cnt=%h stall=%b want f 1", stall_cycles, stall);
        end
        dcache_resp_val = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (stall_cycles !== 4'hF || stall !== 1'b0) begin
            errors++;
            $display("FAIL perf_hold: cnt=%h stall=%b want f 0", stall_cycles, stall);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_dual_issue();
        test_store();
        test_spurious_d();
        test_spurious_i_in_wait_d();
        test_reset_in_flight();
        test_back_to_back();
`ifdef MEM_STALL_PERF_EN
        test_perf_counter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_stall_ctrl
